// File: rtl/gift_key_sched_if.sv
// Load/result bundle for the GIFT-128 key-schedule engine.
// Signal names follow the GiftEnc/GiftDec load convention.
interface gift_key_sched_if #(
    parameter int unsigned ROUNDS_W = 6
);
    logic                inKeyWr;
    logic [127:0]        inKeyData;
    logic [5:0]          inConstData;
    logic                inDir;
    logic [ROUNDS_W-1:0] inRounds;
    logic [127:0]        outKey;
    logic [5:0]          outConst;
    logic [31:0]         outU;
    logic [31:0]         outV;
    logic [5:0]          outRc;
    logic                outRkValid;
    logic                outBusy;
    logic                outDone;

    modport slave (
        input  inKeyWr, inKeyData, inConstData, inDir, inRounds,
        output outKey, outConst, outU, outV, outRc, outRkValid, outBusy, outDone
    );

    modport master (
        output inKeyWr, inKeyData, inConstData, inDir, inRounds,
        input  outKey, outConst, outU, outV, outRc, outRkValid, outBusy, outDone
    );
endinterface

// File: rtl/gift_key_sched.sv
// Iterative GIFT-128 key schedule: one forward or inverse round per clock
// from a loaded key state, emitting round keys U/V and the round constant.
module gift_key_sched #(
    parameter int unsigned ROUNDS_W = 6
) (
    input  logic             inClk,
    input  logic             inRst,
    gift_key_sched_if.slave  bus
);
    localparam int unsigned KEY_W   = 128;
    localparam int unsigned CONST_W = 6;
    localparam int unsigned HALF_W  = 32;

    typedef enum logic {IDLE, RUN} state_e;

    state_e              state_q, state_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [CONST_W-1:0]  const_q, const_d;
    logic                dir_q, dir_d;
    logic [ROUNDS_W-1:0] cnt_q, cnt_d;
    logic [HALF_W-1:0]   u_q, u_d;
    logic [HALF_W-1:0]   v_q, v_d;
    logic [CONST_W-1:0]  rc_q, rc_d;
    logic                rk_valid_q, rk_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [KEY_W-1:0]    key_inv_c;
    logic [CONST_W-1:0]  const_fwd_c;

    // k7'=k1>>>2, k6'=k0>>>12, k5'..k0'=k7..k2
    function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k);
        return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
    endfunction

    // k7..k2=k5'..k0', k1=k7'<<<2, k0=k6'<<<12
    function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k);
        return {k[95:0], k[125:112], k[127:126], k[99:96], k[111:100]};
    endfunction

    function automatic logic [CONST_W-1:0] lfsr_fwd(input logic [CONST_W-1:0] c);
        return {c[4:0], c[5] ^ c[4] ^ 1'b1};
    endfunction

    function automatic logic [CONST_W-1:0] lfsr_inv(input logic [CONST_W-1:0] c);
        return {c[0] ^ c[5] ^ 1'b1, c[5:1]};
    endfunction

    assign key_inv_c   = key_inv(key_q);
    assign const_fwd_c = lfsr_fwd(const_q);

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        const_d    = const_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        u_d        = u_q;
        v_d        = v_q;
        rc_d       = rc_q;
        rk_valid_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.inKeyWr) begin
                    key_d   = bus.inKeyData;
                    const_d = bus.inConstData;
                    dir_d   = bus.inDir;
                    cnt_d   = bus.inRounds;
                    if (bus.inRounds != ROUNDS_W'(0)) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                rk_valid_d = 1'b1;
                // Reverse emits from inv(state) so round numbering matches forward
                if (!dir_q) begin
                    u_d     = key_q[95:64];
                    v_d     = key_q[31:0];
                    rc_d    = const_fwd_c;
                    const_d = const_fwd_c;
                    key_d   = key_fwd(key_q);
                end else begin
                    u_d     = key_inv_c[95:64];
                    v_d     = key_inv_c[31:0];
                    rc_d    = const_q;
                    const_d = lfsr_inv(const_q);
                    key_d   = key_inv_c;
                end
                cnt_d = cnt_q - ROUNDS_W'(1);
                if (cnt_q == ROUNDS_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers, synchronous reset
    always_ff @(posedge inClk) begin
        if (inRst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            const_q    <= '0;
            dir_q      <= 1'b0;
            cnt_q      <= '0;
            u_q        <= '0;
            v_q        <= '0;
            rc_q       <= '0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            const_q    <= const_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            u_q        <= u_d;
            v_q        <= v_d;
            rc_q       <= rc_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.outKey     = key_q;
    assign bus.outConst   = const_q;
    assign bus.outU       = u_q;
    assign bus.outV       = v_q;
    assign bus.outRc      = rc_q;
    assign bus.outRkValid = rk_valid_q;
    assign bus.outBusy    = busy_q;
    assign bus.outDone    = done_q;

endmodule

// File: tb/tb_gift_key_sched.sv
// Directed self-checking bench for gift_key_sched: reset, forward/reverse runs,
// ignored reload, zero-length run and mid-run reset.
module tb_gift_key_sched;
    localparam int unsigned ROUNDS_W = 6;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    gift_key_sched_if #(.ROUNDS_W(ROUNDS_W)) bus ();
    gift_key_sched #(.ROUNDS_W(ROUNDS_W)) dut (.inClk(clk), .inRst(rst), .bus(bus));

    // Published GIFT round constants for rounds 1..40 from c=0
    logic [5:0] rc_tab [1:40] = '{
        6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
        6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
        6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
        6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A};

    logic [31:0] obs_u  [1:40];
    logic [31:0] obs_v  [1:40];
    logic [5:0]  obs_rc [1:40];
    logic [31:0] fwd_u  [1:40];
    logic [31:0] fwd_v  [1:40];
    logic [5:0]  fwd_rc [1:40];

    function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
        return (x >> n) | (x << (16 - n));
    endfunction

    function automatic logic [15:0] w(input logic [127:0] k, input int i);
        return k[i*16 +: 16];
    endfunction

    // Reference model of the forward key update
    function automatic logic [127:0] m_fwd(input logic [127:0] k);
        logic [127:0] r;
        r[127:112] = rotr16(w(k, 1), 2);
        r[111:96]  = rotr16(w(k, 0), 12);
        for (int i = 0; i < 6; i++) r[i*16 +: 16] = w(k, i + 2);
        return r;
    endfunction

    function automatic logic [127:0] m_inv(input logic [127:0] k);
        logic [127:0] r;
        for (int i = 2; i < 8; i++) r[i*16 +: 16] = w(k, i - 2);
        r[31:16] = rotr16(w(k, 7), 14);
        r[15:0]  = rotr16(w(k, 6), 4);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [127:0] k, input logic [5:0] c, input logic d, input int r);
        @(negedge clk);
        bus.inKeyWr     = 1'b1;
        bus.inKeyData   = k;
        bus.inConstData = c;
        bus.inDir       = d;
        bus.inRounds    = ROUNDS_W'(r);
        @(negedge clk);
        bus.inKeyWr     = 1'b0;
    endtask

    // Run R rounds and check every cycle against the model; optional reload glitch
    task automatic run_chk(input logic [127:0] k, input logic [5:0] c, input logic d,
                           input int r, input int glitch_at,
                           output logic [127:0] fk, output logic [5:0] fc);
        logic [127:0] mk;
        logic [5:0]   mc, erc;
        logic [31:0]  eu, ev;
        load(k, c, d, r);
        check("busy_start", 128'(bus.outBusy), 128'(r > 0));
        check("rkv_start", 128'(bus.outRkValid), 128'(0));
        mk = k;
        mc = c;
        for (int i = 1; i <= r; i++) begin
            if (i == glitch_at) begin
                bus.inKeyWr   = 1'b1;
                bus.inKeyData = ~k;
                bus.inRounds  = ROUNDS_W'(3);
            end
            @(negedge clk);
            bus.inKeyWr = 1'b0;
            if (!d) begin
                eu  = mk[95:64];
                ev  = mk[31:0];
                mc  = {mc[4:0], mc[5] ^ mc[4] ^ 1'b1};
                erc = mc;
                mk  = m_fwd(mk);
            end else begin
                mk  = m_inv(mk);
                eu  = mk[95:64];
                ev  = mk[31:0];
                erc = mc;
                mc  = {mc[0] ^ mc[5] ^ 1'b1, mc[5:1]};
            end
            check("rkv", 128'(bus.outRkValid), 128'(1));
            check("u", 128'(bus.outU), 128'(eu));
            check("v", 128'(bus.outV), 128'(ev));
            check("rc", 128'(bus.outRc), 128'(erc));
            check("busy", 128'(bus.outBusy), 128'(i < r));
            check("done", 128'(bus.outDone), 128'(i == r));
            if (i <= 40) begin
                obs_u[i]  = bus.outU;
                obs_v[i]  = bus.outV;
                obs_rc[i] = bus.outRc;
            end
        end
        if (r == 0) begin
            check("done_r0", 128'(bus.outDone), 128'(1));
            check("rkv_r0", 128'(bus.outRkValid), 128'(0));
        end
        check("key_final", bus.outKey, mk);
        check("const_final", 128'(bus.outConst), 128'(mc));
        @(negedge clk);
        check("done_clear", 128'(bus.outDone), 128'(0));
        check("rkv_clear", 128'(bus.outRkValid), 128'(0));
        check("busy_idle", 128'(bus.outBusy), 128'(0));
        fk = mk;
        fc = mc;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_key"}, bus.outKey, 128'(0));
        check({tag, "_const"}, 128'(bus.outConst), 128'(0));
        check({tag, "_uv"}, 128'({bus.outU, bus.outV}), 128'(0));
        check({tag, "_rc"}, 128'(bus.outRc), 128'(0));
        check({tag, "_flags"}, 128'({bus.outRkValid, bus.outBusy, bus.outDone}), 128'(0));
    endtask

    initial begin
        logic [127:0] fk, fk2;
        logic [5:0]   fc, fc2;
        localparam logic [127:0] K3   = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        localparam logic [127:0] KMST = 128'hfedcba9876543210fedcba9876543210;
        int seen_done;

        bus.inKeyWr = 1'b0; bus.inKeyData = '0; bus.inConstData = '0;
        bus.inDir = 1'b0; bus.inRounds = '0;

        // Reset for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Master key 0, 40 forward rounds: published constant sequence
        run_chk(128'(0), 6'h00, 1'b0, 40, 0, fk, fc);
        for (int i = 1; i <= 40; i++) check("rc_tab", 128'(obs_rc[i]), 128'(rc_tab[i]));
        check("s2_key", fk, 128'(0));
        check("s2_const", 128'(fc), 128'(6'h1A));

        // Single forward round, hand values
        run_chk(K3, 6'h00, 1'b0, 1, 0, fk, fc);
        check("s3_u", 128'(obs_u[1]), 128'(32'h00050004));
        check("s3_v", 128'(obs_v[1]), 128'(32'h00010000));
        check("s3_rc", 128'(obs_rc[1]), 128'(6'h01));
        check("s3_key", bus.outKey, 128'h4000_0000_0007_0006_0005_0004_0003_0002);
        check("s3_const", 128'(bus.outConst), 128'(6'h01));

        // Forward then reverse: reverse stream is forward stream reversed
        run_chk(KMST, 6'h00, 1'b0, 40, 0, fk, fc);
        for (int i = 1; i <= 40; i++) begin
            fwd_u[i] = obs_u[i]; fwd_v[i] = obs_v[i]; fwd_rc[i] = obs_rc[i];
        end
        run_chk(fk, fc, 1'b1, 40, 0, fk2, fc2);
        for (int j = 1; j <= 40; j++) begin
            check("rev_u", 128'(obs_u[j]), 128'(fwd_u[41 - j]));
            check("rev_v", 128'(obs_v[j]), 128'(fwd_v[41 - j]));
            check("rev_rc", 128'(obs_rc[j]), 128'(fwd_rc[41 - j]));
        end
        check("rev_key", bus.outKey, KMST);
        check("rev_const", 128'(bus.outConst), 128'(0));

        // Reload during run is ignored
        run_chk(128'(0), 6'h00, 1'b0, 40, 5, fk, fc);
        check("glitch_key", bus.outKey, 128'(0));
        check("glitch_const", 128'(bus.outConst), 128'(6'h1A));

        // Zero-length run
        run_chk(K3, 6'h15, 1'b0, 0, 0, fk, fc);
        check("r0_key", bus.outKey, K3);
        check("r0_const", 128'(bus.outConst), 128'(6'h15));

        // Reset mid-run aborts with no done
        load(KMST, 6'h00, 1'b0, 40);
        repeat (9) @(negedge clk);
        check("abort_busy_pre", 128'(bus.outBusy), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (bus.outDone || bus.outBusy || bus.outRkValid) seen_done++;
        end
        check("abort_quiet", 128'(seen_done), 128'(0));

        // Single-round run reproduces its hand values after the abort
        run_chk(K3, 6'h00, 1'b0, 1, 0, fk, fc);
        check("s6_u", 128'(obs_u[1]), 128'(32'h00050004));
        check("s6_v", 128'(obs_v[1]), 128'(32'h00010000));
        check("s6_key", bus.outKey, 128'h4000_0000_0007_0006_0005_0004_0003_0002);
        check("s6_const", 128'(bus.outConst), 128'(6'h01));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
